// File: rtl/button_conditioner.sv
// Conditions the raw up/down push buttons: two-flop synchroniser, debounce,
// press pulse with auto-repeat, and mutual exclusion between the two directions.
module button_conditioner #(
    parameter int CW         = 25,
    parameter int DB_COUNT   = 1000000,
    parameter int HOLD_COUNT = 25000000,
    parameter int RPT_COUNT  = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic up_raw,
    input  logic down_raw,
    output logic up,
    output logic down,
    output logic up_level,
    output logic down_level
);
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    localparam logic [CW-1:0] DB_LAST   = CW'(DB_COUNT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_COUNT - 1);
    localparam logic [CW-1:0] RPT_LAST  = CW'(RPT_COUNT - 1);

    // Index 0 is the up button, index 1 the down button.
    logic          raw         [2];
    logic          sync1_reg   [2];
    logic          sync2_reg   [2];
    logic          level_reg   [2];
    logic          level_next  [2];
    logic [CW-1:0] db_cnt_reg  [2];
    logic [CW-1:0] db_cnt_next [2];
    state_t        state_reg   [2];
    state_t        state_next  [2];
    logic [CW-1:0] timer_reg   [2];
    logic [CW-1:0] timer_next  [2];
    logic          pulse_reg   [2];
    logic          pulse_next  [2];

    assign raw[0] = up_raw;
    assign raw[1] = down_raw;

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        localparam int OTHER = 1 - gi;
        logic blocked;

        // Looking at the other button's next level as well as its current one
        // keeps the pulses exclusive when both levels rise on the same edge.
        assign blocked = level_reg[OTHER] | level_next[OTHER];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync1_reg[gi]  <= 1'b0;
                sync2_reg[gi]  <= 1'b0;
                level_reg[gi]  <= 1'b0;
                db_cnt_reg[gi] <= '0;
                state_reg[gi]  <= IDLE;
                timer_reg[gi]  <= '0;
                pulse_reg[gi]  <= 1'b0;
            end else begin
                sync1_reg[gi]  <= raw[gi];
                sync2_reg[gi]  <= sync1_reg[gi];
                level_reg[gi]  <= level_next[gi];
                db_cnt_reg[gi] <= db_cnt_next[gi];
                state_reg[gi]  <= state_next[gi];
                timer_reg[gi]  <= timer_next[gi];
                pulse_reg[gi]  <= pulse_next[gi];
            end
        end

        always_comb begin
            level_next[gi]  = level_reg[gi];
            db_cnt_next[gi] = '0;
            if (sync2_reg[gi] != level_reg[gi]) begin
                if (db_cnt_reg[gi] == DB_LAST) begin
                    level_next[gi] = sync2_reg[gi];
                end else begin
                    db_cnt_next[gi] = db_cnt_reg[gi] + CW'(1);
                end
            end
        end

        // The FSM acts on the next level so the press pulse and the level edge
        // appear on the outputs in the same cycle.
        always_comb begin
            state_next[gi] = state_reg[gi];
            timer_next[gi] = timer_reg[gi];
            pulse_next[gi] = 1'b0;
            case (state_reg[gi])
                IDLE: begin
                    if (level_next[gi]) begin
                        state_next[gi] = HOLD;
                        timer_next[gi] = '0;
                        pulse_next[gi] = !blocked;
                    end
                end
                HOLD: begin
                    if (!level_next[gi]) begin
                        state_next[gi] = IDLE;
                        timer_next[gi] = '0;
                    end else if (blocked) begin
                        timer_next[gi] = '0;
                    end else if (timer_reg[gi] == HOLD_LAST) begin
                        state_next[gi] = REPEAT;
                        timer_next[gi] = '0;
                        pulse_next[gi] = 1'b1;
                    end else begin
                        timer_next[gi] = timer_reg[gi] + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!level_next[gi]) begin
                        state_next[gi] = IDLE;
                        timer_next[gi] = '0;
                    end else if (blocked) begin
                        timer_next[gi] = '0;
                    end else if (timer_reg[gi] == RPT_LAST) begin
                        timer_next[gi] = '0;
                        pulse_next[gi] = 1'b1;
                    end else begin
                        timer_next[gi] = timer_reg[gi] + CW'(1);
                    end
                end
                default: begin
                    state_next[gi] = IDLE;
                    timer_next[gi] = '0;
                end
            endcase
        end
    end

    assign up         = pulse_reg[0];
    assign down       = pulse_reg[1];
    assign up_level   = level_reg[0];
    assign down_level = level_reg[1];
endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed press scenarios plus
// randomized bouncy stimulus against an event-level reference model.
module tb_button_conditioner;
    localparam int CW = 8;
    localparam int DB = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic up_raw = 1'b0;
    logic down_raw = 1'b0;
    logic up, down, up_level, down_level;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .CW(CW), .DB_COUNT(DB), .HOLD_COUNT(HC), .RPT_COUNT(RC)
    ) dut (
        .clk(clk), .reset(reset), .up_raw(up_raw), .down_raw(down_raw),
        .up(up), .down(down), .up_level(up_level), .down_level(down_level)
    );

    if (DB >= (1 << CW) || HC >= (1 << CW) || RC >= (1 << CW)) begin : g_param_bad
        initial $fatal(1, "FAIL param_range: a count parameter does not fit in CW bits");
    end

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: synchronised samples, debounced levels, and for each
    // held button the cycle at which its next pulse is due.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_lvl [2];
    bit m_pulse [2];
    bit m_fired [2];
    int m_run [2];
    int m_due [2];
    int m_cyc = 0;

    // Per-phase observation records.
    int k;
    int up_times[$];
    int down_times[$];
    int up_rise;
    int down_fall;
    int up_lvl_cycles;
    bit prev_dl;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_pulse[b] = 0;
            m_fired[b] = 0; m_run[b] = 0; m_due[b] = -1;
        end
    endtask

    task automatic model_edge();
        bit raw_now [2];
        bit new_lvl [2];
        bit new_p [2];
        bit supp;
        bit rose;
        raw_now[0] = up_raw;
        raw_now[1] = down_raw;
        if (!reset) begin
            model_clear();
            return;
        end
        m_cyc++;
        for (int b = 0; b < 2; b++) begin
            new_lvl[b] = m_lvl[b];
            if (m_s2[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == DB) begin
                    new_lvl[b] = m_s2[b];
                    m_run[b] = 0;
                end
            end else begin
                m_run[b] = 0;
            end
        end
        for (int b = 0; b < 2; b++) begin
            new_p[b] = 0;
            supp = new_lvl[1-b] | m_lvl[1-b];
            if (!new_lvl[b]) begin
                m_fired[b] = 0;
                m_due[b] = -1;
            end else begin
                rose = !m_lvl[b];
                if (rose) m_fired[b] = 0;
                if (supp) begin
                    m_due[b] = m_cyc + (m_fired[b] ? RC : HC);
                end else if (rose) begin
                    new_p[b] = 1;
                    m_due[b] = m_cyc + HC;
                end else if (m_cyc == m_due[b]) begin
                    new_p[b] = 1;
                    m_fired[b] = 1;
                    m_due[b] = m_cyc + RC;
                end
            end
        end
        for (int b = 0; b < 2; b++) begin
            m_s2[b] = m_s1[b];
            m_s1[b] = raw_now[b];
            m_lvl[b] = new_lvl[b];
            m_pulse[b] = new_p[b];
        end
    endtask

    task automatic step();
        int kk;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        kk = k;
        k++;
        check("up", int'(up), int'(m_pulse[0]));
        check("down", int'(down), int'(m_pulse[1]));
        check("up_level", int'(up_level), int'(m_lvl[0]));
        check("down_level", int'(down_level), int'(m_lvl[1]));
        check("exclusive", int'(up & down), 0);
        if (up) up_times.push_back(kk);
        if (down) down_times.push_back(kk);
        if (up_level) up_lvl_cycles++;
        if (up_level && up_rise < 0) up_rise = kk;
        if (!down_level && prev_dl && down_fall < 0) down_fall = kk;
        prev_dl = down_level;
    endtask

    task automatic begin_phase();
        k = 0;
        up_times.delete();
        down_times.delete();
        up_rise = -1;
        down_fall = -1;
        up_lvl_cycles = 0;
        prev_dl = down_level;
    endtask

    // Asserts reset part-way through a cycle, then holds it for n edges.
    task automatic apply_reset(input int n);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("rst_async_up", int'(up), 0);
        check("rst_async_down", int'(down), 0);
        check("rst_async_up_level", int'(up_level), 0);
        check("rst_async_down_level", int'(down_level), 0);
        repeat (n) step();
        reset = 1'b1;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int count_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
        return n;
    endfunction

    initial begin
        bit bseq [9];
        int p;
        model_clear();

        // Reset held with the up button already pressed.
        up_raw = 1'b1;
        begin_phase();
        repeat (3) step();
        reset = 1'b1;
        begin_phase();
        repeat (10) step();
        check("t1_level_latency", up_rise, 5);
        check("t1_pulse_count", up_times.size(), 1);
        check("t1_pulse_cycle", qget(up_times, 0), 5);
        $display("phase reset-release: up_level at %0d, up pulses %0d", up_rise, up_times.size());
        up_raw = 1'b0;
        repeat (12) step();

        // Clean tap.
        begin_phase();
        up_raw = 1'b1;
        repeat (8) step();
        up_raw = 1'b0;
        repeat (14) step();
        check("t2_pulse_count", up_times.size(), 1);
        check("t2_pulse_cycle", qget(up_times, 0), 5);
        check("t2_level_cycles", up_lvl_cycles, 8);
        check("t2_down_pulses", down_times.size(), 0);
        $display("phase tap: up pulse at %0d, up_level cycles %0d", qget(up_times, 0), up_lvl_cycles);

        // Bouncy press.
        bseq = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
        begin_phase();
        for (int i = 0; i < 9; i++) begin
            up_raw = bseq[i];
            step();
        end
        up_raw = 1'b0;
        repeat (14) step();
        check("t3_pulse_count", up_times.size(), 1);
        check("t3_pulse_cycle", qget(up_times, 0), 10);
        $display("phase bounce: up pulse at %0d, pulses %0d", qget(up_times, 0), up_times.size());

        // Auto-repeat on a held down button.
        begin_phase();
        down_raw = 1'b1;
        repeat (40) step();
        down_raw = 1'b0;
        repeat (20) step();
        p = qget(down_times, 0);
        check("t4_press_cycle", p, 5);
        check("t4_hold_gap", qget(down_times, 1) - qget(down_times, 0), HC);
        check("t4_rpt_gap1", qget(down_times, 2) - qget(down_times, 1), RC);
        check("t4_rpt_gap2", qget(down_times, 3) - qget(down_times, 2), RC);
        check("t4_nine_pulses", count_in(down_times, p, p + 31), 9);
        check("t4_ninth_cycle", qget(down_times, 8), p + 31);
        check("t4_after_release", count_in(down_times, down_fall, 1000), 0);
        check("t4_up_pulses", up_times.size(), 0);
        $display("phase repeat: down pulses %0d, first %0d, level fell at %0d", down_times.size(), p, down_fall);

        // Both buttons together, then down released.
        begin_phase();
        up_raw = 1'b1;
        down_raw = 1'b1;
        repeat (30) step();
        check("t5_up_while_both", up_times.size(), 0);
        check("t5_down_while_both", down_times.size(), 0);
        down_raw = 1'b0;
        repeat (25) step();
        up_raw = 1'b0;
        repeat (14) step();
        check("t5_down_fall", down_fall, 35);
        check("t5_first_up_delay", qget(up_times, 0) - down_fall, HC);
        check("t5_up_rpt_gap", qget(up_times, 1) - qget(up_times, 0), RC);
        check("t5_down_total", down_times.size(), 0);
        $display("phase simultaneous: down fell at %0d, first up pulse at %0d", down_fall, qget(up_times, 0));

        // Reset while auto-repeating.
        begin_phase();
        up_raw = 1'b1;
        repeat (25) step();
        check("t6_pre_reset_pulses", up_times.size(), 5);
        apply_reset(2);
        begin_phase();
        repeat (10) step();
        check("t6_level_latency", up_rise, 5);
        check("t6_pulse_count", up_times.size(), 1);
        check("t6_pulse_cycle", qget(up_times, 0), 5);
        $display("phase reset-mid-repeat: up_level at %0d, up pulses %0d", up_rise, up_times.size());
        up_raw = 1'b0;
        repeat (12) step();

        // Randomized bouncy presses with occasional resets.
        begin_phase();
        for (int seg = 0; seg < 160; seg++) begin
            int len;
            bit u_lvl;
            bit d_lvl;
            len = int'($urandom_range(1, 30));
            u_lvl = ($urandom_range(0, 2) != 0);
            d_lvl = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) apply_reset(int'($urandom_range(1, 3)));
            for (int c = 0; c < len; c++) begin
                up_raw = u_lvl ^ ($urandom_range(0, 7) == 0);
                down_raw = d_lvl ^ ($urandom_range(0, 7) == 0);
                step();
            end
        end
        $display("phase random: %0d cycles, up pulses %0d, down pulses %0d", k, up_times.size(), down_times.size());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions the two raw push-button inputs from the board before they drive the up/down inputs of the data-memory/display block.
- Synchronises, debounces and edge-detects each button, and emits single-cycle step pulses.
- Holding a button auto-repeats the pulse.
- Sits between the board pins and the dmemory up/down ports in the maxmin top level.

Parameters:
- CW, 25: width of all internal timing counters; must hold the largest count parameter.
- DB_COUNT, 1000000: consecutive stable cycles required to accept a level change.
- HOLD_COUNT, 25000000: cycles from the press pulse to the first auto-repeat pulse.
- RPT_COUNT, 5000000: cycles between subsequent auto-repeat pulses.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-low reset. Asserted when 0; released synchronously to clk.
- up_raw  in  1  raw up button pin; asynchronous, bouncy; 1 = pressed.
- down_raw  in  1  raw down button pin; asynchronous, bouncy; 1 = pressed.
- up  out  1  one-cycle step pulse for the up direction (to dmemory up).
- down  out  1  one-cycle step pulse for the down direction (to dmemory down).
- up_level  out  1  debounced level of the up button.
- down_level  out  1  debounced level of the down button.

Behaviour:
- Reset (reset=0, asynchronous): all synchroniser flops, counters and FSMs clear. up, down, up_level and down_level are all 0. Reset asserted mid-hold or mid-debounce aborts immediately; no pulse follows on release.
- Synchroniser: two flops per button, reset to 0. Debounce logic sees only the second flop (s).
- Debounce, per button:
  - If s == level, the counter clears to 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DB_COUNT-1 while s != level, level <= s and the counter clears.
  - Any bounce (s returns to level) before that point clears the counter.
- Latency: a level stable at the pin before clock edge E0 sets level after edge E0+1+DB_COUNT (2 synchroniser edges + DB_COUNT debounce edges).
- Per-button FSM states: IDLE, HOLD, REPEAT.
  - IDLE: on level 0->1, pulse for 1 cycle in the same cycle level first reads 1; go to HOLD with the timer cleared.
  - HOLD: timer increments each cycle. At HOLD_COUNT-1, pulse for 1 cycle, clear the timer and go to REPEAT.
  - REPEAT: timer increments each cycle. At RPT_COUNT-1, pulse for 1 cycle and clear the timer.
  - HOLD or REPEAT with level 0: go to IDLE and clear the timer; no pulse.
- Pulse spacing while held: press pulse at cycle P, then P+HOLD_COUNT, then P+HOLD_COUNT+k*RPT_COUNT (k >= 1).
- Mutual exclusion (up and down are never 1 in the same cycle):
  - While the other button's level is 1, this button's pulses are suppressed and its timer is held at 0. Its FSM state still follows its own level.
  - If both levels rise in the same cycle, neither pulses; both FSMs go to HOLD with timers held.
  - When one is released, the remaining held button's timer runs from 0; its next pulse comes HOLD_COUNT or RPT_COUNT cycles later, according to its state.
- Counter widths: all counters are CW bits and never wrap. Parameter values >= 2^CW are illegal; the bench checks this with an elaboration-time assertion.
- Outputs are registered; no combinational path from raw inputs to outputs.

Test Plan (DB_COUNT=4, HOLD_COUNT=10, RPT_COUNT=3, CW=8):
1. Reset: hold reset=0 for 3 cycles with up_raw=1 -> all outputs 0 throughout. After release with up_raw still 1, up_level rises after 2+4 edges and up pulses exactly once in that cycle.
2. Clean tap: up_raw 0->1 for 8 cycles, then 0 -> one up pulse at cycle E0+5 relative to the first sampling edge. up_level high for 8 cycles, delayed the same amount. No repeat; down stays 0.
3. Bounce: up_raw toggles 1,0,1,1,0,1,1,1,1 -> no level change until 4 consecutive synchronised 1s. Exactly one up pulse.
4. Auto-repeat: down_raw held 40 cycles -> down pulses at P, P+10, P+13, P+16, … (9 pulses, the last at P+31). The pulse train stops after level drops.
5. Simultaneous: up_raw and down_raw rise together and are held 30 cycles -> zero pulses on both. Release down -> up pulses 10 cycles after down_level falls, then every 3 cycles.
6. Reset mid-repeat: assert reset during REPEAT -> up/down/levels go 0 asynchronously before the next edge. After release with the button still held, normal press behaviour restarts (debounce, then one pulse).
